edge_event_unit: RTL
====================

Name: edge_event_unit

Overview:
- Multi-channel, parametrised edge detector; successor to the single-bit rising-edge detector.
- Per channel: asynchronous input synchroniser, glitch filter, and edge detection selectable per channel (rise/fall/both/off).
- Per channel: sticky event flag with per-channel clear, plus a masked, registered interrupt output.
- Sits between raw pad/peripheral signals and the register/interrupt logic.

Parameters:
- CHANNELS, 8: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- FILTER_LEN, 4: consecutive cycles the synchronised value must differ from the filtered level before it is accepted (>=1).
- CNT_W, $clog2(FILTER_LEN+1): filter counter width, derived; do not override.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  global enable for filter/edge logic.
- data_in  in  CHANNELS  raw, possibly asynchronous inputs.
- mode  in  2*CHANNELS  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- clr  in  CHANNELS  per-channel sticky clear, level-sensitive, sampled each clk.
- irq_mask  in  CHANNELS  1 = channel contributes to irq.
- level  out  CHANNELS  filtered, synchronised level.
- edge_pulse  out  CHANNELS  one-cycle pulse per qualified edge.
- sticky  out  CHANNELS  latched event flags.
- irq  out  1  registered OR of (sticky & irq_mask).

Behaviour:
- Reset: at a clk edge with rst=1, all synchroniser flops, filter counters, level, edge_pulse, sticky and irq go to 0. rst overrides ena and clr.
- Level reset to 0: an input held at 1 through reset produces a rising edge after the normal latency once rst drops.
- Synchroniser: a SYNC_STAGES-deep shift chain per channel. It always runs, independent of ena. Its last stage is sync_out[i].
- Filter, when ena=1, per channel, with counter c:
  - sync_out != level and c == FILTER_LEN-1: level <= sync_out, c <= 0.
  - sync_out != level otherwise: c <= c+1.
  - sync_out == level: c <= 0.
  - A disagreement shorter than FILTER_LEN cycles never changes level.
- ena=0: all c held at 0, level holds, edge_pulse forced 0, sticky holds, clr still effective.
- On re-enable, any pending sync_out/level difference is filtered normally and reported as an edge.
- Edge detection: in the cycle level[i] toggles, edge_pulse[i] is registered high on the same clock edge. Qualification uses mode[i] as sampled on that edge:
  - 0->1 qualifies with mode 01 or 11.
  - 1->0 qualifies with mode 10 or 11.
  - mode 00 gives no pulse; level still tracks.
- Pulse width: edge_pulse is high for exactly one cycle, then returns to 0 unless another qualified transition occurs. A new transition needs at least FILTER_LEN cycles, so back-to-back pulses occur only when FILTER_LEN=1.
- Latency: edge 1 is the first clk edge sampling a new, stable data_in. level and edge_pulse update on edge SYNC_STAGES+FILTER_LEN; with defaults, edge 6.
- Sticky: sticky[i] sets on the same edge as edge_pulse[i]=1. Otherwise clr[i]=1 clears it on the next edge.
- Simultaneous set and clear: set wins, so no event is lost.
- irq <= |(sticky & irq_mask), one cycle after sticky or irq_mask changes.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with data_in=0 -> level, edge_pulse, sticky all 8'h00 and irq=0, both during rst and 20 cycles after release.
- Rise latency: defaults, mode=all 01, data_in[0] 0->1 sampled on edge 1 -> level[0]=1 and edge_pulse[0]=1 on edge 6 only; sticky[0]=1 from edge 6 on; irq=1 on edge 7 with irq_mask[0]=1.
- Glitch reject: data_in[3] high for 3 cycles (FILTER_LEN=4) -> level[3], edge_pulse[3] and sticky[3] stay 0. A 4-cycle high -> rising pulse, then falling transition with no pulse under mode 01.
- Modes: channel 1 in mode 10, channel 2 in 11, channel 5 in 00; toggle each 0->1->0 with 10-cycle holds -> ch1 one pulse on the fall, ch2 two pulses, ch5 none but level follows.
- Clear priority: a qualified edge on ch4 coincides with clr[4]=1 -> sticky[4] stays 1. clr[4]=1 on a later idle cycle -> sticky[4]=0 next edge; irq drops one cycle after.
- Enable/reset mid-operation: ena=0 while data_in[6] rises -> no pulse, level holds. ena=1 -> pulse FILTER_LEN edges later. Asserting rst during an active filter count -> all state 0 on that edge, no pulse afterward for input already 0.

Source files
------------

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: synchroniser, glitch filter, edge select,
// sticky flags and a masked, registered interrupt.
module edge_event_unit #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = $clog2(FILTER_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [CHANNELS-1:0]   data_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  input  logic [CHANNELS-1:0]   irq_mask,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   sticky,
  output logic                  irq
);

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  pulse_q, pulse_d;
  logic [CHANNELS-1:0]                  sticky_q, sticky_d;
  logic [CHANNELS-1:0]                  sync_out;
  logic                                 irq_q, irq_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // mode bit 0 qualifies rising edges, bit 1 falling edges
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    cnt_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ena && (sync_out[i] != level_q[i])) begin
        if (cnt_q[i] == CMAX) begin
          level_d[i] = sync_out[i];
          pulse_d[i] = sync_out[i] ? mode[2*i] : mode[2*i+1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    sticky_d = pulse_d | (sticky_q & ~clr);
    irq_d    = |(sticky_q & irq_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], data_in};
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
    end
  end

  assign level      = level_q;
  assign edge_pulse = pulse_q;
  assign sticky     = sticky_q;
  assign irq        = irq_q;

endmodule
